// File: rtl/button_gesture_if.sv
// Button gesture bus: debounced level in, one-cycle gesture pulses and status levels out.
// The slave modport is the gesture classifier; master is the environment driving the button.
interface button_gesture_if;
   logic btn_state;
   logic click;
   logic double_click;
   logic long_press;
   logic auto_repeat;
   logic held;
   logic busy;

   modport master (
      output btn_state,
      input  click, double_click, long_press, auto_repeat, held, busy
   );

   modport slave (
      input  btn_state,
      output click, double_click, long_press, auto_repeat, held, busy
   );
endinterface

// File: rtl/button_gesture.sv
// Classifies a debounced button level into click / double click / long press pulses.
// Optional auto-repeat while held is enabled by defining BUTTON_GESTURE_AUTOREPEAT_EN.
module button_gesture #(
   parameter int unsigned LONG_CYCLES   = 25000000,
   parameter int unsigned DCLICK_CYCLES = 12500000,
   parameter int unsigned REPEAT_CYCLES = 5000000,
   parameter int unsigned CNT_W         = 25
) (
   input logic               CLK,
   input logic               RST,
   button_gesture_if.slave   bus
);

   localparam int unsigned MaxLd     = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
   localparam int unsigned MaxCycles = (MaxLd > REPEAT_CYCLES) ? MaxLd : REPEAT_CYCLES;

   if (LONG_CYCLES < 2 || DCLICK_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
      $error("button_gesture: cycle parameters must be >= 2");
   end
   if ($clog2(MaxCycles) > CNT_W) begin : g_bad_width
      $error("button_gesture: CNT_W too narrow for cycle parameters");
   end

   localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYCLES - 1);
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {StIdle, StPress1, StGap, StLock, StHeld} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_prev_q, btn_prev_d;
   logic             click_q, click_d;
   logic             dclick_q, dclick_d;
   logic             long_q, long_d;
   logic             held_q, held_d;
   logic             busy_q, busy_d;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
   logic             rpt_q, rpt_d;
`endif

   logic press_edge;
   assign press_edge = bus.btn_state & ~btn_prev_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      btn_prev_d = bus.btn_state;
      click_d    = 1'b0;
      dclick_d   = 1'b0;
      long_d     = 1'b0;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
      rpt_d      = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (press_edge) begin
               state_d = StPress1;
               cnt_d   = '0;
            end
         end
         StPress1: begin
            // Release takes priority over reaching the long threshold.
            if (!bus.btn_state) begin
               state_d = StGap;
               cnt_d   = '0;
            end else if (cnt_q == LongLast) begin
               state_d = StHeld;
               long_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StGap: begin
            if (bus.btn_state) begin
               state_d  = StLock;
               dclick_d = 1'b1;
            end else if (cnt_q == DclickLast) begin
               state_d = StIdle;
               click_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StLock: begin
            if (!bus.btn_state) state_d = StIdle;
         end
         StHeld: begin
            if (!bus.btn_state) begin
               state_d = StIdle;
            end
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
            else if (cnt_q == RepeatLast) begin
               rpt_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
      held_d = (state_d == StHeld);
   end

   // btn_prev resets high so a button held through reset must be released first.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         btn_prev_q <= 1'b1;
         click_q    <= 1'b0;
         dclick_q   <= 1'b0;
         long_q     <= 1'b0;
         held_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
         rpt_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         btn_prev_q <= btn_prev_d;
         click_q    <= click_d;
         dclick_q   <= dclick_d;
         long_q     <= long_d;
         held_q     <= held_d;
         busy_q     <= busy_d;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
         rpt_q      <= rpt_d;
`endif
      end
   end

   assign bus.click        = click_q;
   assign bus.double_click = dclick_q;
   assign bus.long_press   = long_q;
   assign bus.held         = held_q;
   assign bus.busy         = busy_q;
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
   assign bus.auto_repeat  = rpt_q;
`else
   assign bus.auto_repeat  = 1'b0;
`endif

endmodule

// File: tb/tb_button_gesture.sv
// Directed bench for button_gesture with LONG=8, DCLICK=5, REPEAT=3.
// Expected repeat pulses follow BUTTON_GESTURE_AUTOREPEAT_EN.
module tb_button_gesture;

   localparam int unsigned Long   = 8;
   localparam int unsigned Dclick = 5;
   localparam int unsigned Rep    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   button_gesture_if bus ();

   button_gesture #(
      .LONG_CYCLES   (Long),
      .DCLICK_CYCLES (Dclick),
      .REPEAT_CYCLES (Rep),
      .CNT_W         (4)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mask(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic check_quiet(input string tag);
      check_eq({tag, " click"},  32'(bus.click), 0);
      check_eq({tag, " dclick"}, 32'(bus.double_click), 0);
      check_eq({tag, " long"},   32'(bus.long_press), 0);
      check_eq({tag, " repeat"}, 32'(bus.auto_repeat), 0);
      check_eq({tag, " held"},   32'(bus.held), 0);
      check_eq({tag, " busy"},   32'(bus.busy), 0);
   endtask

   // pat[k] is the button level sampled at edge k; outputs checked just after edge k.
   task automatic run_case(input string name, input int n, input logic [63:0] pat,
                           input int exp_click, input int exp_dclick, input int exp_long,
                           input logic [63:0] held_exp, input logic [63:0] busy_exp,
                           input logic [63:0] rpt_exp);
      for (int k = 0; k < n; k++) begin
         bus.btn_state = pat[k];
         @(posedge clk);
         #1;
         check_eq($sformatf("%s k=%0d click", name, k),  32'(bus.click), 32'(k == exp_click));
         check_eq($sformatf("%s k=%0d dclick", name, k), 32'(bus.double_click),
                  32'(k == exp_dclick));
         check_eq($sformatf("%s k=%0d long", name, k),   32'(bus.long_press), 32'(k == exp_long));
         check_eq($sformatf("%s k=%0d repeat", name, k), 32'(bus.auto_repeat), 32'(rpt_exp[k]));
         check_eq($sformatf("%s k=%0d held", name, k),   32'(bus.held), 32'(held_exp[k]));
         check_eq($sformatf("%s k=%0d busy", name, k),   32'(bus.busy), 32'(busy_exp[k]));
      end
      bus.btn_state = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [63:0] rpt_hold20;
   logic [63:0] rpt_hold16;

   initial begin
`ifdef BUTTON_GESTURE_AUTOREPEAT_EN
      rpt_hold20 = mask(11, 11) | mask(14, 14) | mask(17, 17);
      rpt_hold16 = mask(11, 11) | mask(14, 14);
`else
      rpt_hold20 = '0;
      rpt_hold16 = '0;
`endif
      bus.btn_state = 1'b0;
      #1;
      check_quiet("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("post_reset_idle");

      run_case("click", 14, mask(0, 2), 8, -1, -1, '0, mask(0, 7), '0);
      run_case("dclick_hold", 32, mask(0, 1) | mask(4, 24), -1, 4, -1, '0, mask(0, 24), '0);
      run_case("long", 26, mask(0, 19), -1, -1, 8, mask(8, 19), mask(0, 19), rpt_hold20);
      run_case("release_at_long", 16, mask(0, 7), 13, -1, -1, '0, mask(0, 12), '0);
      run_case("repeat16", 20, mask(0, 15), -1, -1, 8, mask(8, 15), mask(0, 15), rpt_hold16);
      run_case("press_at_timeout", 16, mask(0, 1) | mask(7, 8), -1, 7, -1, '0, mask(0, 8), '0);

      // Reset during a hold, released with the button still pressed.
      bus.btn_state = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("pre_abort busy", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check_quiet("abort_in_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         check_quiet($sformatf("held_thru_reset k=%0d", k));
      end
      bus.btn_state = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_quiet($sformatf("release_after_reset k=%0d", k));
      end
      run_case("click_after_reset", 14, mask(0, 2), 8, -1, -1, '0, mask(0, 7), '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
